// File: rtl/spi_cmd_decoder_pkg.sv
// Shared opcodes and parser states for the SPI command decoder.
package spi_cmd_pkg;

  localparam logic [7:0] OP_MEM_WR = 8'h01;
  localparam logic [7:0] OP_REG_WR = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_MEM_DATA,
    ST_REG_ADDR,
    ST_REG_DATA,
    ST_DISCARD
  } state_t;

endpackage

// File: rtl/spi_cmd_decoder_sync.sv
// Single-bit multi-flop synchronizer for signals arriving from the SPI clock domain.
module sync_ff #(
  parameter int SyncStages = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic D,
  output logic Q
);

  logic [SyncStages-1:0] stages;

  always_ff @(posedge Clk) begin
    if (Reset) stages <= '0;
    else       stages <= {stages[SyncStages-2:0], D};
  end

  assign Q = stages[SyncStages-1];

endmodule

// File: rtl/spi_cmd_decoder.sv
// Parses SPI bytes into VRAM write frames (opcode 0x01) and register write frames (opcode 0x02).
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int AddrWidth  = 16,
  parameter int SyncStages = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 SpiByteStrobe,
  input  logic                 SpiCSel,
  input  logic [7:0]           SpiData,
  output logic [AddrWidth-1:0] MemAddr,
  output logic [7:0]           MemData,
  output logic                 MemReq,
  input  logic                 MemAck,
  output logic [7:0]           RegAddr,
  output logic [7:0]           RegData,
  output logic                 RegWe,
  output logic                 FrameActive,
  output logic                 Overrun
);

  logic   strobeSync, cselSync;
  logic   strobePrev, cselPrev;
  logic   byteEvent;
  logic   [7:0] holdData;
  logic   [7:0] addrHi;
  logic   cselFall, cselRise;
  state_t state;

  sync_ff #(.SyncStages(SyncStages)) uStrobeSync (
    .Clk(Clk), .Reset(Reset), .D(SpiByteStrobe), .Q(strobeSync)
  );

  sync_ff #(.SyncStages(SyncStages)) uCselSync (
    .Clk(Clk), .Reset(Reset), .D(SpiCSel), .Q(cselSync)
  );

  // cselPrev clears to 0 so a CSel still low after reset is not seen as a new frame.
  assign cselFall = cselPrev & ~cselSync;
  assign cselRise = ~cselPrev & cselSync;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      strobePrev <= 1'b0;
      cselPrev   <= 1'b0;
      byteEvent  <= 1'b0;
      holdData   <= 8'h00;
    end else begin
      strobePrev <= strobeSync;
      cselPrev   <= cselSync;
      byteEvent  <= strobeSync & ~strobePrev;
      if (strobeSync && !strobePrev) holdData <= SpiData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      MemAddr     <= '0;
      MemData     <= 8'h00;
      MemReq      <= 1'b0;
      RegAddr     <= 8'h00;
      RegData     <= 8'h00;
      RegWe       <= 1'b0;
      FrameActive <= 1'b0;
      Overrun     <= 1'b0;
      addrHi      <= 8'h00;
    end else begin
      RegWe       <= 1'b0;
      FrameActive <= ~cselSync;
      if (RegWe) RegAddr <= RegAddr + 8'd1;
      // A pending VRAM write completes regardless of frame state.
      if (MemReq && MemAck) begin
        MemReq  <= 1'b0;
        MemAddr <= MemAddr + AddrWidth'(1);
      end
      if (cselRise) begin
        state <= ST_IDLE;
      end else if (cselFall) begin
        state   <= ST_CMD;
        Overrun <= 1'b0;
      end else if (byteEvent) begin
        case (state)
          ST_CMD: begin
            if (holdData == OP_MEM_WR)      state <= ST_ADDR_HI;
            else if (holdData == OP_REG_WR) state <= ST_REG_ADDR;
            else                            state <= ST_DISCARD;
          end
          ST_ADDR_HI: begin
            addrHi <= holdData;
            state  <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            MemAddr <= AddrWidth'({addrHi, holdData});
            state   <= ST_MEM_DATA;
          end
          ST_MEM_DATA: begin
            if (MemReq && !MemAck) begin
              Overrun <= 1'b1;
            end else begin
              MemData <= holdData;
              MemReq  <= 1'b1;
            end
          end
          ST_REG_ADDR: begin
            RegAddr <= holdData;
            state   <= ST_REG_DATA;
          end
          ST_REG_DATA: begin
            RegData <= holdData;
            RegWe   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed scoreboard bench for spi_cmd_decoder: VRAM/register frames, wrap, overrun, discard, reset.
module tb_spi_cmd_decoder;

  localparam int AddrWidth  = 16;
  localparam int SyncStages = 2;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 SpiByteStrobe;
  logic                 SpiCSel;
  logic [7:0]           SpiData;
  logic [AddrWidth-1:0] MemAddr;
  logic [7:0]           MemData;
  logic                 MemReq;
  logic                 MemAck;
  logic [7:0]           RegAddr;
  logic [7:0]           RegData;
  logic                 RegWe;
  logic                 FrameActive;
  logic                 Overrun;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t expQ[$];
  int  errors = 0;
  int  checks = 0;
  int  strobeAge = 0;
  int  memReqCount = 0;
  int  regWeCount = 0;
  int  savedMem, savedReg;
  logic memReqPrev = 1'b0;

  spi_cmd_decoder #(.AddrWidth(AddrWidth), .SyncStages(SyncStages)) dut (
    .Clk(Clk), .Reset(Reset), .SpiByteStrobe(SpiByteStrobe), .SpiCSel(SpiCSel),
    .SpiData(SpiData), .MemAddr(MemAddr), .MemData(MemData), .MemReq(MemReq),
    .MemAck(MemAck), .RegAddr(RegAddr), .RegData(RegData), .RegWe(RegWe),
    .FrameActive(FrameActive), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  // Count write activity on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    if (MemReq && !memReqPrev) memReqCount++;
    memReqPrev = MemReq;
    if (RegWe) regWeCount++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    strobeAge++;
    if (strobeAge == 3) SpiByteStrobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    SpiData       = b;
    SpiByteStrobe = 1'b1;
    strobeAge     = 0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b);
    idle(8);
  endtask

  task automatic frameStart();
    SpiCSel = 1'b0;
    idle(6);
  endtask

  task automatic frameEnd();
    SpiCSel = 1'b1;
    idle(6);
  endtask

  task automatic expectMem(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    expQ.push_back(w);
  endtask

  task automatic memWrite(input logic [7:0] b, input bit doAck);
    int  n;
    wr_t w;
    applyStimulus(b);
    n = 0;
    while (!MemReq && n < 20) begin
      tick();
      n++;
    end
    checkOutput("memreq_seen", {31'd0, MemReq}, 32'd1);
    checkOutput("memreq_latency", n, SyncStages + 2);
    checkOutput("sb_nonempty", {31'd0, expQ.size() != 0}, 32'd1);
    if (expQ.size() != 0) begin
      w = expQ.pop_front();
      checkOutput("mem_addr", {16'd0, MemAddr}, {16'd0, w.addr});
      checkOutput("mem_data", {24'd0, MemData}, {24'd0, w.data});
    end
    if (doAck) begin
      tick();
      MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      checkOutput("memreq_drop", {31'd0, MemReq}, 32'd0);
    end
    idle(4);
  endtask

  task automatic regWrite(input logic [7:0] b, input logic [7:0] expAddr);
    int n;
    applyStimulus(b);
    n = 0;
    while (!RegWe && n < 20) begin
      tick();
      n++;
    end
    checkOutput("regwe_seen", {31'd0, RegWe}, 32'd1);
    checkOutput("regwe_latency", n, SyncStages + 2);
    checkOutput("reg_addr", {24'd0, RegAddr}, {24'd0, expAddr});
    checkOutput("reg_data", {24'd0, RegData}, {24'd0, b});
    tick();
    checkOutput("regwe_pulse", {31'd0, RegWe}, 32'd0);
    idle(4);
  endtask

  initial begin
    Reset = 1'b1;
    SpiByteStrobe = 1'b0;
    SpiCSel = 1'b1;
    SpiData = 8'h00;
    MemAck = 1'b0;
    idle(3);
    checkOutput("rst_memreq", {31'd0, MemReq}, 32'd0);
    checkOutput("rst_regwe", {31'd0, RegWe}, 32'd0);
    checkOutput("rst_frame", {31'd0, FrameActive}, 32'd0);
    checkOutput("rst_overrun", {31'd0, Overrun}, 32'd0);
    checkOutput("rst_memaddr", {16'd0, MemAddr}, 32'd0);
    Reset = 1'b0;
    idle(6);
    checkOutput("idle_frame", {31'd0, FrameActive}, 32'd0);

    $display("[TB] VRAM frame 01 12 34 AA BB");
    frameStart();
    checkOutput("frame_active", {31'd0, FrameActive}, 32'd1);
    sendByte(8'h01);
    sendByte(8'h12);
    sendByte(8'h34);
    expectMem(16'h1234, 8'hAA);
    expectMem(16'h1235, 8'hBB);
    memWrite(8'hAA, 1'b1);
    memWrite(8'hBB, 1'b1);
    frameEnd();
    checkOutput("frame_inactive", {31'd0, FrameActive}, 32'd0);

    $display("[TB] VRAM address wrap at FFFF");
    frameStart();
    sendByte(8'h01);
    sendByte(8'hFF);
    sendByte(8'hFF);
    expectMem(16'hFFFF, 8'h01);
    expectMem(16'h0000, 8'h02);
    memWrite(8'h01, 1'b1);
    memWrite(8'h02, 1'b1);
    frameEnd();

    $display("[TB] unknown opcode and truncated address frame");
    savedMem = memReqCount;
    savedReg = regWeCount;
    frameStart();
    sendByte(8'h7E);
    sendByte(8'h11);
    sendByte(8'h22);
    sendByte(8'h33);
    frameEnd();
    frameStart();
    sendByte(8'h01);
    sendByte(8'h12);
    frameEnd();
    checkOutput("discard_memreq", memReqCount, savedMem);
    checkOutput("discard_regwe", regWeCount, savedReg);

    $display("[TB] register frame 02 FF 11 22");
    frameStart();
    sendByte(8'h02);
    sendByte(8'hFF);
    regWrite(8'h11, 8'hFF);
    regWrite(8'h22, 8'h00);
    frameEnd();

    $display("[TB] overrun with MemAck held low");
    frameStart();
    sendByte(8'h01);
    sendByte(8'h00);
    sendByte(8'h10);
    expectMem(16'h0010, 8'h55);
    memWrite(8'h55, 1'b0);
    applyStimulus(8'h66);
    idle(8);
    checkOutput("ovr_memreq_held", {31'd0, MemReq}, 32'd1);
    checkOutput("ovr_data_kept", {24'd0, MemData}, 32'h55);
    checkOutput("ovr_addr_kept", {16'd0, MemAddr}, 32'h0010);
    checkOutput("ovr_set", {31'd0, Overrun}, 32'd1);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    checkOutput("ovr_ack_drop", {31'd0, MemReq}, 32'd0);
    frameEnd();
    checkOutput("ovr_sticky", {31'd0, Overrun}, 32'd1);
    frameStart();
    checkOutput("ovr_cleared", {31'd0, Overrun}, 32'd0);
    frameEnd();

    $display("[TB] reset while MemReq is pending");
    frameStart();
    sendByte(8'h01);
    sendByte(8'h00);
    sendByte(8'h20);
    expectMem(16'h0020, 8'h77);
    memWrite(8'h77, 1'b0);
    applyStimulus(8'h88);
    idle(8);
    checkOutput("pre_rst_overrun", {31'd0, Overrun}, 32'd1);
    Reset = 1'b1;
    tick();
    checkOutput("mrst_memreq", {31'd0, MemReq}, 32'd0);
    checkOutput("mrst_memaddr", {16'd0, MemAddr}, 32'd0);
    checkOutput("mrst_memdata", {24'd0, MemData}, 32'd0);
    checkOutput("mrst_regaddr", {24'd0, RegAddr}, 32'd0);
    checkOutput("mrst_regdata", {24'd0, RegData}, 32'd0);
    checkOutput("mrst_regwe", {31'd0, RegWe}, 32'd0);
    checkOutput("mrst_frame", {31'd0, FrameActive}, 32'd0);
    checkOutput("mrst_overrun", {31'd0, Overrun}, 32'd0);
    Reset = 1'b0;
    idle(4);
    savedMem = memReqCount;
    savedReg = regWeCount;
    sendByte(8'h99);
    sendByte(8'h01);
    idle(4);
    checkOutput("post_rst_ignored_mem", memReqCount, savedMem);
    checkOutput("post_rst_ignored_reg", regWeCount, savedReg);
    frameEnd();

    checkOutput("sb_drained", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
# spi_cmd_decoder

Consumes bytes from the SPI byte receiver, moves them from the SPI clock domain into the system clock domain, and parses them into write frames. Frames either write video memory (16-bit start address, auto-increment) or write control registers (8-bit start address, auto-increment). It sits between the SPI receiver and the VRAM arbiter / register file of the VGA core.

## Interface
Parameters:
- AddrWidth, 16, VRAM address width; address bytes beyond this width are truncated (upper bits dropped).
- SyncStages, 2, flip-flop depth of each input synchronizer (≥2).

Ports:
- Clk  in  1  system clock; one clock, all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- SpiByteStrobe  in  1  byte-received strobe from the receiver (SPI clock domain, asynchronous here).
- SpiCSel  in  1  chip select from the receiver, low = frame active (asynchronous).
- SpiData  in  8  received byte; stable for at least SyncStages+3 Clk cycles after SpiByteStrobe rises.
- MemAddr  out  AddrWidth  VRAM write address.
- MemData  out  8  VRAM write data.
- MemReq  out  1  VRAM write request; held until MemAck.
- MemAck  in  1  VRAM write accepted this cycle.
- RegAddr  out  8  register write address.
- RegData  out  8  register write data.
- RegWe  out  1  single-cycle register write strobe.
- FrameActive  out  1  synchronized, inverted SpiCSel.
- Overrun  out  1  sticky: a data byte was dropped in the current frame.

## Operation
- SpiByteStrobe and SpiCSel each pass through a SyncStages synchronizer; a rising edge of synced strobe = byte event; SpiData is captured into a holding register on that cycle.
- Opcodes: 0x01 VRAM write, 0x02 register write; any other opcode → DISCARD.
- States: IDLE → (CSel falls) CMD → (0x01) ADDR_HI → ADDR_LO → MEM_DATA; (0x02) REG_ADDR → REG_DATA; (other) DISCARD.
- ADDR_HI/ADDR_LO load MemAddr {hi,lo}, truncated to AddrWidth. REG_ADDR loads RegAddr.
- MEM_DATA: each byte drives MemData, asserts MemReq; on MemAck, MemReq drops and MemAddr increments mod 2^AddrWidth.
- REG_DATA: each byte drives RegData, pulses RegWe one cycle, then RegAddr increments mod 256 the following cycle.
- Synced CSel rise from any state → IDLE. An outstanding MemReq is kept until MemAck even after frame end. Partial address frames perform no write.
- Byte event while MemReq high and MemAck low → byte dropped, Overrun set. MemAck and byte event in the same cycle → ack completes, byte accepted, no overrun.
- Overrun clears on synced CSel fall (new frame) or Reset.

## Timing
- Reset: state IDLE; MemAddr, MemData, RegAddr, RegData = 0; MemReq, RegWe, FrameActive, Overrun = 0; synchronizers cleared.
- Strobe rise → byte event detected SyncStages+1 cycles later; MemReq/RegWe asserted on the next cycle (latency SyncStages+2).
- MemReq may fall no earlier than the cycle after MemAck is sampled high.
- Minimum byte spacing: SyncStages+4 Clk cycles, plus VRAM ack latency for MEM_DATA.
- Reset mid-frame: immediate return to reset values; the remainder of the SPI frame is ignored until the next CSel fall.

## Structure
- Package spi_cmd_pkg: opcode constants (OP_MEM_WR = 8'h01, OP_REG_WR = 8'h02) and the state enum.
- Sub-module sync_ff (parameter SyncStages, 1-bit), instantiated for strobe and CSel.

## Test plan
- CSel low, bytes 01 12 34 AA BB, MemAck one cycle after each MemReq → writes 0x1234=AA, 0x1235=BB; MemReq latency SyncStages+2.
- Bytes 02 FF 11 22 → RegWe pulses: 0xFF=11, then 0x00=22 (wrap).
- AddrWidth=16, address FFFF, two data bytes → writes FFFF, then 0000.
- MemAck held low, two data bytes → first held on MemReq, second dropped, Overrun=1; new frame clears Overrun.
- Opcode 0x7E followed by 3 bytes → no MemReq/RegWe; CSel rise → IDLE. Frame 01 12 cut after ADDR_HI → no write.
- Reset asserted while MemReq high → next cycle all outputs 0, state IDLE.
